// File: rtl/ps2_scancode_receiver_if.sv
// ps2_scancode_receiver_if: byte-delivery bus from the PS/2 receiver to downstream logic
// Signals: scancode (last delivered byte), keyPressed (delivery strobe),
//          parity_err / frame_err (one-cycle error strobes).
// Modports: master = receiver (drives), slave = consumer (reads).
interface ps2_scancode_receiver_if;
  logic [7:0] scancode;
  logic       keyPressed;
  logic       parity_err;
  logic       frame_err;
  modport master(output scancode, keyPressed, parity_err, frame_err);
  modport slave(input scancode, keyPressed, parity_err, frame_err);
endinterface

// File: rtl/ps2_scancode_receiver.sv
// ps2_scancode_receiver: deserializes PS/2 device-to-host frames into scancode bytes
// Ports: clk (system clock), rstn (sync active-low reset), ps2_clk / ps2_data (raw
//        async pins), bus (master: scancode, keyPressed, parity_err, frame_err).
// Params: FILTER_LEN (clock glitch filter length), TIMEOUT_CYCLES (>= 2, watchdog).
// Build option: define PS2_BREAK_FILTER_EN to swallow 8'hF0 and the byte after it.
module ps2_scancode_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic clk,
  input  logic rstn,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_scancode_receiver_if.master bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
  // wd reads 0 in the cycle after a fall, so firing at T-2 registers frame_err
  // exactly TIMEOUT_CYCLES cycles after the fall cycle.
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 2);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [1:0] ck_s, dt_s;
  logic [FW-1:0] flt_cnt;
  logic ck_f, ck_fd;
  logic [WW-1:0] wd;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic par_ok;
  logic d, hit, fall, timeout, ev, valid, perr, ferr, deliver;
  assign d = dt_s[1];
  // flt_cnt measures how long the synchronized clock has disagreed with the filtered one
  assign hit = (ck_s[1] != ck_f) && flt_cnt == FLT_MAX;
  assign fall = ck_fd & ~ck_f;
  assign timeout = state != IDLE && wd == WD_MAX;
  // a fall coinciding with the timeout is dropped
  assign ev = fall && !timeout;
  always_comb begin
    state_n = state;
    valid = 1'b0;
    perr = 1'b0;
    ferr = timeout;
    if (timeout) state_n = IDLE;
    else if (fall)
      case (state)
        IDLE:    state_n = d ? IDLE : DATA;
        DATA:    state_n = bit_cnt == 3'd7 ? PARITY : DATA;
        PARITY:  state_n = STOP;
        STOP: begin
          state_n = IDLE;
          ferr = !d;
          valid = d && par_ok;
          perr = d && !par_ok;
        end
        default: state_n = IDLE;
      endcase
  end
`ifdef PS2_BREAK_FILTER_EN
  logic brk;
  assign deliver = valid && !brk && shreg != 8'hF0;
  always_ff @(posedge clk) begin
    if (!rstn) brk <= 1'b0;
    else brk <= valid ? (!brk && shreg == 8'hF0) : (perr || ferr) ? 1'b0 : brk;
  end
`else
  assign deliver = valid;
`endif
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ck_s <= 2'b11;
      dt_s <= 2'b11;
      flt_cnt <= '0;
      ck_f <= 1'b1;
      ck_fd <= 1'b1;
      state <= IDLE;
      wd <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      par_ok <= 1'b0;
      bus.scancode <= 8'h00;
      bus.keyPressed <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      ck_s <= {ck_s[0], ps2_clk};
      dt_s <= {dt_s[0], ps2_data};
      flt_cnt <= (ck_s[1] != ck_f && !hit) ? flt_cnt + 1'b1 : '0;
      ck_f <= hit ? ck_s[1] : ck_f;
      ck_fd <= ck_f;
      state <= state_n;
      wd <= (state == IDLE || fall) ? '0 : wd + 1'b1;
      bit_cnt <= (ev && state == IDLE) ? '0 : (ev && state == DATA) ? bit_cnt + 1'b1 : bit_cnt;
      shreg <= (ev && state == IDLE) ? '0 : (ev && state == DATA) ? {d, shreg[7:1]} : shreg;
      par_ok <= (ev && state == PARITY) ? ^{shreg, d} : par_ok;
      bus.scancode <= deliver ? shreg : bus.scancode;
      bus.keyPressed <= deliver;
      bus.parity_err <= perr;
      bus.frame_err <= ferr;
    end
  end
endmodule
